data_sram_resp: RTL
===================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the number of 32-bit words stored.
REQ-002 SHALL have parameter LAT, default 1, meaning read latency in cycles from accept to earliest resp_valid; legal range 1..4.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  initiator presents a request.
REQ-006 SHALL have port req_ready  out  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  in  4  byte write enables; 4'b0000 = read.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  write data, byte lane i = bits 8i+7:8i.
REQ-010 SHALL have port resp_valid  out  1  response data valid.
REQ-011 SHALL have port resp_ready  in  1  initiator accepts response.
REQ-012 SHALL have port resp_rdata  out  32  read data; 32'b0 for write responses.

Function
REQ-013 Accept SHALL occur on a rising edge where req_valid & req_ready; no other request state is consumed.
REQ-014 Word index SHALL be req_addr[DEPTH_LOG2+1:2]; bits 1:0 and upper bits ignored; index wraps modulo 2^DEPTH_LOG2.
REQ-015 On accepted write, each byte lane with req_we[i]=1 SHALL be updated at the accept edge; other lanes unchanged.
REQ-016 On accepted read, array word SHALL be sampled at the accept edge, so a read accepted the cycle after a write to the same word returns new data.
REQ-017 Every accepted request SHALL produce exactly one response; responses in accept order.
REQ-018 Response SHALL become visible on resp_valid exactly LAT cycles after accept when no backpressure is pending ahead of it.
REQ-019 Response SHALL pop on a rising edge where resp_valid & resp_ready; resp_valid and resp_rdata SHALL hold stable while resp_valid & ~resp_ready.
REQ-020 Outstanding counter SHALL count accepted-but-unpopped responses, range 0..LAT+1; +1 on accept, -1 on pop, unchanged on simultaneous accept and pop.
REQ-021 req_ready SHALL equal (outstanding < LAT+1), registered-state only; no combinational path from resp_ready or req_valid.
REQ-022 With resp_ready held 1, SHALL sustain one accept per cycle indefinitely (full throughput).
REQ-023 When outstanding = LAT+1, req_ready SHALL be 0; a pop that cycle raises req_ready on the next cycle.
REQ-024 Response storage (delay line plus queue) SHALL hold LAT+1 entries; overflow SHALL be impossible given REQ-021.

Reset
REQ-025 On rst: resp_valid=0, resp_rdata=0, outstanding=0, req_ready=1 in the following cycle, all in-flight responses discarded.
REQ-026 rst mid-operation SHALL drop pending responses without emitting them; array contents SHALL NOT be cleared.
REQ-027 A request presented during rst SHALL NOT be accepted and SHALL NOT write the array.

Structure
REQ-028 Shared package SHALL hold LAT_MIN=1, LAT_MAX=4, data width 32, byte-enable width 4.
REQ-029 One sub-module resp_fifo (synchronous FIFO, depth LAT+1, 32-bit, full/empty flags) SHALL implement the response queue; array and latency delay line stay in data_sram_resp.

Verification
REQ-030 LAT=1: write addr 0x10 we=4'hF data 0xDEADBEEF, next cycle read 0x10 -> response 1 = 0x0, response 2 = 0xDEADBEEF one cycle after read accept.
REQ-031 Byte enables: preload 0x11223344 at 0x20, write we=4'b0101 data 0xAABBCCDD -> read 0x20 returns 0x11BB33DD.
REQ-032 Backpressure LAT=2: resp_ready=0, req_valid=1 continuous -> exactly 3 accepts, req_ready=0 thereafter; release resp_ready -> 3 responses in order, then accepts resume.
REQ-033 Throughput LAT=1: 100 back-to-back reads with resp_ready=1 -> 100 accepts in 100 cycles, each response 1 cycle after its accept.
REQ-034 Wrap: DEPTH_LOG2=4, write 0x40 data 0x5, read 0x00 -> 0x00000005.
REQ-035 Reset mid-flight: 2 reads outstanding, assert rst 1 cycle -> no responses emitted, resp_valid=0, req_ready=1 after reset, array data intact on subsequent read.

Source files
------------

// File: rtl/data_sram_resp_pkg.sv
// Shared widths, latency limits and byte-lane merge helper for the response-buffered data SRAM.
package data_sram_resp_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  // Outstanding counter must reach LAT_MAX+1.
  localparam int CNT_W   = $clog2(LAT_MAX + 2);

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res_s;
    res_s = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        res_s[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res_s;
  endfunction

endpackage

// File: rtl/data_sram_resp_fifo.sv
// Synchronous response queue with full/empty flags; read data is forced to zero while empty.
module resp_fifo
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     cnt_r;
  logic              do_push_s, do_pop_s;

  assign full      = (cnt_r == CW'(DEPTH));
  assign empty     = (cnt_r == CW'(0));
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rd_data   = empty ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy update; pointers wrap at DEPTH, which need not be a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      cnt_r    <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= (wr_ptr_r == PW'(DEPTH - 1)) ? PW'(0) : wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(DEPTH - 1)) ? PW'(0) : rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Word-addressed SRAM with byte-lane writes, fixed read latency LAT and a backpressurable response queue.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LAT        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BE_W-1:0]   req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata
);

  localparam int WORDS = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_r [WORDS];
  logic [DEPTH_LOG2-1:0] idx_s;
  logic                  acc_s, pop_s, is_read_s;
  logic [DATA_W-1:0]     rd_word_s;
  logic                  push_v_s;
  logic [DATA_W-1:0]     push_d_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]      out_r, out_next_s;
  logic                  req_ready_r;
  logic                  unused_s;

  assign idx_s     = req_addr[DEPTH_LOG2+1:2];
  // Requests seen while rst is high must neither be accepted nor write the array.
  assign acc_s     = req_valid & req_ready_r & ~rst;
  assign pop_s     = resp_valid & resp_ready;
  assign is_read_s = (req_we == 4'b0000);
  assign rd_word_s = is_read_s ? mem_r[idx_s] : 32'h0000_0000;
  assign unused_s  = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0], fifo_full_s};

  // Array write at the accept edge; never cleared by reset.
  always_ff @(posedge clk) begin
    if (acc_s && !is_read_s) begin
      mem_r[idx_s] <= merge_bytes(mem_r[idx_s], req_wdata, req_we);
    end
  end

  // Latency delay line: LAT-1 register stages ahead of the queue, whose output is visible on the push edge.
  if (LAT == 1) begin : g_no_dl
    assign push_v_s = acc_s;
    assign push_d_s = rd_word_s;
  end else begin : g_dl
    logic [LAT-2:0]    v_r;
    logic [DATA_W-1:0] d_r [LAT-1];

    // Shift responses toward the queue, one stage per cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= '0;
        for (int i = 0; i < LAT - 1; i++) begin
          d_r[i] <= 32'h0000_0000;
        end
      end else begin
        v_r[0] <= acc_s;
        d_r[0] <= rd_word_s;
        for (int i = 1; i < LAT - 1; i++) begin
          v_r[i] <= v_r[i-1];
          d_r[i] <= d_r[i-1];
        end
      end
    end

    assign push_v_s = v_r[LAT-2];
    assign push_d_s = d_r[LAT-2];
  end

  resp_fifo #(.DEPTH(LAT + 1)) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_v_s),
    .push_data (push_d_s),
    .pop       (pop_s),
    .rd_data   (resp_rdata),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign resp_valid = ~fifo_empty_s;

  // Next outstanding count.
  always_comb begin
    out_next_s = out_r;
    case ({acc_s, pop_s})
      2'b10:   out_next_s = out_r + CNT_W'(1);
      2'b01:   out_next_s = out_r - CNT_W'(1);
      default: out_next_s = out_r;
    endcase
  end

  // Outstanding count and registered ready, so req_ready has no combinational input path.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r       <= CNT_W'(0);
      req_ready_r <= 1'b1;
    end else begin
      out_r       <= out_next_s;
      req_ready_r <= (out_next_s < CNT_W'(LAT + 1));
    end
  end

  assign req_ready = req_ready_r;

endmodule
